// File: rtl/gpio_spi_sched.sv
// Round-robin scheduler and SPI master for the GPIO expander array.
// Each granted request becomes one 16-bit mode-0 frame to one expander; the response goes back to its requester.
module gpio_spi_sched #(
    parameter int REQ_NUM   = 2,
    parameter int SLAVE_NUM = 2,
    parameter int CLK_DIV   = 2
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [REQ_NUM-1:0]     req_valid,
    output logic [REQ_NUM-1:0]     req_ready,
    input  logic [REQ_NUM-1:0]     req_wr,
    input  logic [2*REQ_NUM-1:0]   req_slave,
    input  logic [2*REQ_NUM-1:0]   req_sel,
    input  logic [3*REQ_NUM-1:0]   req_addr,
    input  logic [8*REQ_NUM-1:0]   req_wdata,
    output logic [REQ_NUM-1:0]     rsp_valid,
    output logic [7:0]             rsp_rdata,
    output logic                   rsp_err,
    output logic                   sclk,
    output logic                   mosi,
    input  logic [SLAVE_NUM-1:0]   miso,
    output logic [SLAVE_NUM-1:0]   ss,
    output logic                   busy
);
    localparam int CW = $clog2(CLK_DIV + 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_cnt;
    logic [15:0]          frame;
    logic [15:0]          capture;
    logic [1:0]           slave_q;
    logic [1:0]           owner;
    logic [1:0]           last_gnt;

    logic                 gnt_any;
    logic [1:0]           gnt_idx;
    logic [1:0]           cand;
    logic [REQ_NUM-1:0]   gnt_onehot;
    logic [15:0]          gnt_frame;
    logic [1:0]           gnt_slave;
    logic [REQ_NUM-1:0]   owner_onehot;
    logic [SLAVE_NUM-1:0] sel_onehot;
    logic                 miso_bit;
    logic                 slave_bad;
    logic                 div_done;
    logic                 take;

    // Search starts one past the last winner so every requester gets a turn.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int off = 1; off <= REQ_NUM; off++) begin
            cand = 2'((int'(last_gnt) + off) % REQ_NUM);
            for (int k = 0; k < REQ_NUM; k++) begin
                if (!gnt_any && cand == 2'(k) && req_valid[k]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
    end

    always_comb begin
        gnt_onehot   = '0;
        gnt_frame    = '0;
        gnt_slave    = '0;
        owner_onehot = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            if (gnt_idx == 2'(k)) begin
                gnt_onehot[k] = 1'b1;
                gnt_frame     = {req_wr[k], req_sel[2*k +: 2], req_addr[3*k +: 3], 2'b00,
                                 req_wr[k] ? req_wdata[8*k +: 8] : 8'h00};
                gnt_slave     = req_slave[2*k +: 2];
            end
            owner_onehot[k] = (owner == 2'(k));
        end
    end

    always_comb begin
        sel_onehot = '0;
        miso_bit   = 1'b0;
        for (int i = 0; i < SLAVE_NUM; i++) begin
            sel_onehot[i] = (slave_q == 2'(i));
            miso_bit      = miso_bit | (miso[i] & sel_onehot[i]);
        end
    end

    assign slave_bad = (int'(slave_q) >= SLAVE_NUM);
    assign div_done  = (cnt == CW'(CLK_DIV));
    // The last GAP cycle doubles as IDLE so back-to-back grants are 34*CLK_DIV+1 apart.
    assign take      = gnt_any && (state == IDLE || (state == GAP && div_done));

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            frame     <= '0;
            capture   <= '0;
            slave_q   <= '0;
            owner     <= '0;
            last_gnt  <= 2'(REQ_NUM - 1);
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            sclk      <= 1'b0;
            mosi      <= 1'b0;
            ss        <= '1;
            busy      <= 1'b0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            case (state)
                IDLE: ;
                SETUP: begin
                    if (cnt == '0) begin
                        if (slave_bad) begin
                            rsp_valid <= owner_onehot;
                            rsp_rdata <= '0;
                            rsp_err   <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            ss   <= ~sel_onehot;
                            mosi <= frame[15];
                            cnt  <= cnt + 1'b1;
                        end
                    end else if (div_done) begin
                        sclk    <= 1'b1;
                        capture <= {capture[14:0], miso_bit};
                        bit_cnt <= '0;
                        cnt     <= CW'(1);
                        state   <= SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (div_done) begin
                        cnt <= CW'(1);
                        if (!sclk) begin
                            sclk    <= 1'b1;
                            capture <= {capture[14:0], miso_bit};
                        end else begin
                            sclk    <= 1'b0;
                            frame   <= {frame[14:0], 1'b0};
                            mosi    <= frame[14];
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 4'd15) state <= HOLD;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (div_done) begin
                        ss        <= '1;
                        mosi      <= 1'b0;
                        rsp_valid <= owner_onehot;
                        rsp_rdata <= capture[7:0];
                        rsp_err   <= 1'b0;
                        cnt       <= CW'(1);
                        state     <= GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (div_done) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (take) begin
                req_ready <= gnt_onehot;
                frame     <= gnt_frame;
                slave_q   <= gnt_slave;
                owner     <= gnt_idx;
                last_gnt  <= gnt_idx;
                cnt       <= '0;
                busy      <= 1'b1;
                state     <= SETUP;
            end
        end
    end
endmodule
